// File: rtl/dip_debouncer_if.sv
// DIP switch debouncer interface: raw switch inputs and debounced outputs.
// The optional change strobe exists only when DIP_DEBOUNCE_CHANGE_EN is defined.
interface dip_debouncer_if;
  logic [3:0] s1_raw;
  logic [3:0] s2_raw;
  logic [3:0] s1;
  logic [3:0] s2;
`ifdef DIP_DEBOUNCE_CHANGE_EN
  logic       changed;

  modport master (
    output s1_raw,
    output s2_raw,
    input  s1,
    input  s2,
    input  changed
  );

  modport slave (
    input  s1_raw,
    input  s2_raw,
    output s1,
    output s2,
    output changed
  );
`else
  modport master (
    output s1_raw,
    output s2_raw,
    input  s1,
    input  s2
  );

  modport slave (
    input  s1_raw,
    input  s2_raw,
    output s1,
    output s2
  );
`endif
endinterface

// File: rtl/dip_debouncer.sv
// Eight-channel DIP switch debouncer ({s2_raw, s1_raw}).
// Each bit has a 2-flop synchronizer, a saturating qualification counter and a
// stable register. A bit is accepted after DEBOUNCE_CYCLES consecutive cycles
// of disagreement between its synchronized value and its stable value.
// Optional feature macro: DIP_DEBOUNCE_CHANGE_EN adds a one-cycle 'changed'
// strobe, high in the cycle after any stable bit updates.
module dip_debouncer #(
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int CNT_W           = 16
) (
  input  logic            clk,
  input  logic            reset,
  dip_debouncer_if.slave  dip
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       stable;
  logic [7:0]       upd;
  logic [CNT_W-1:0] cnt [8];

  // Two-flop synchronizer; nothing else ever looks at the raw switch bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {dip.s2_raw, dip.s1_raw};
      sync2 <= sync1;
    end
  end

  // A bit is accepted when it still disagrees and its counter has reached terminal count.
  always_comb begin
    upd = '0;
    for (int i = 0; i < 8; i++) begin
      upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Per-bit qualification counters: cleared on agreement or acceptance, so they never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stable registers take the synchronized value only for accepted bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
    end else begin
      stable <= (stable & ~upd) | (sync2 & upd);
    end
  end

  assign dip.s1 = stable[3:0];
  assign dip.s2 = stable[7:4];

`ifdef DIP_DEBOUNCE_CHANGE_EN
  logic changed_q;

  // Single strobe per edge no matter how many bits were accepted together.
  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd;
    end
  end

  assign dip.changed = changed_q;
`endif

endmodule

// File: tb/tb_dip_debouncer.sv
// Directed testbench for dip_debouncer with DEBOUNCE_CYCLES=4, CNT_W=3, plus a
// DEBOUNCE_CYCLES=1 instance sharing the same raw inputs.
// Change-strobe checks are active when DIP_DEBOUNCE_CHANGE_EN is defined.
module tb_dip_debouncer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   chg_cnt;

  dip_debouncer_if dif ();
  dip_debouncer_if dif1 ();

  assign dif1.s1_raw = dif.s1_raw;
  assign dif1.s2_raw = dif.s2_raw;

  dip_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .dip   (dif)
  );

  dip_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .dip   (dif1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
`ifdef DIP_DEBOUNCE_CHANGE_EN
    if (dif.changed === 1'b1) chg_cnt++;
`endif
  endtask

  task automatic hold_check(input string tag, input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {24'h0, dif.s2, dif.s1}, {24'h0, exp});
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    chg_cnt = 0;

    // Reset with switches high: outputs held at zero, then a normal rise.
    reset      = 1'b1;
    dif.s1_raw = 4'hF;
    dif.s2_raw = 4'h0;
    tick();
    chk("rst_out0", {24'h0, dif.s2, dif.s1}, 32'h00);
    tick();
    chk("rst_out1", {24'h0, dif.s2, dif.s1}, 32'h00);
`ifdef DIP_DEBOUNCE_CHANGE_EN
    chk("rst_chg", {31'h0, dif.changed}, 32'h0);
`endif
    chg_cnt = 0;
    reset   = 1'b0;
    hold_check("rst_hold", 5, 8'h00);
    tick();
    chk("rst_rise", {24'h0, dif.s2, dif.s1}, 32'h0F);
`ifdef DIP_DEBOUNCE_CHANGE_EN
    chk("rst_chg_cnt", chg_cnt, 1);
`endif

    // Clean change: back to 0, then 0 -> A.
    dif.s1_raw = 4'h0;
    repeat (8) tick();
    chk("clr_settle", {24'h0, dif.s2, dif.s1}, 32'h00);
    chk("clr_settle_d1", {28'h0, dif1.s1}, 32'h0);
    chg_cnt    = 0;
    dif.s1_raw = 4'hA;
    tick();                                   // edge k
    chk("clean_k", {24'h0, dif.s2, dif.s1}, 32'h00);
    chk("d1_k", {28'h0, dif1.s1}, 32'h0);
    tick();                                   // edge k+1
    chk("d1_k1", {28'h0, dif1.s1}, 32'h0);
    tick();                                   // edge k+2
    chk("d1_k2", {28'h0, dif1.s1}, 32'hA);
    chk("clean_k2", {24'h0, dif.s2, dif.s1}, 32'h00);
    hold_check("clean_k34", 2, 8'h00);        // edges k+3, k+4
    tick();                                   // edge k+5
    chk("clean_k5", {24'h0, dif.s2, dif.s1}, 32'h0A);
`ifdef DIP_DEBOUNCE_CHANGE_EN
    chk("clean_chg_hi", {31'h0, dif.changed}, 32'h1);
    tick();
    chk("clean_chg_lo", {31'h0, dif.changed}, 32'h0);
    chk("clean_chg_cnt", chg_cnt, 1);
`endif

    // Glitch: s2_raw[0] high for 3 cycles only.
    chg_cnt    = 0;
    dif.s2_raw = 4'h1;
    repeat (3) tick();
    dif.s2_raw = 4'h0;
    hold_check("glitch", 12, 8'h0A);
`ifdef DIP_DEBOUNCE_CHANGE_EN
    chk("glitch_chg_cnt", chg_cnt, 0);
`endif

    // Bounce: s2_raw[3] toggles every 2 cycles for 20 cycles, then holds 1.
    for (int seg = 0; seg < 10; seg++) begin
      dif.s2_raw[3] = (seg % 2 == 0);
      hold_check("bounce", 2, 8'h0A);
    end
    dif.s2_raw[3] = 1'b1;
    hold_check("bounce_hold", 5, 8'h0A);
    tick();
    chk("bounce_rise", {24'h0, dif.s2, dif.s1}, 32'h8A);

    // Simultaneous change on both banks.
    chg_cnt    = 0;
    dif.s1_raw = 4'h3;
    dif.s2_raw = 4'hC;
    hold_check("simul_wait", 5, 8'h8A);
    tick();
    chk("simul_rise", {24'h0, dif.s2, dif.s1}, 32'hC3);
    hold_check("simul_hold", 2, 8'hC3);
`ifdef DIP_DEBOUNCE_CHANGE_EN
    chk("simul_chg_cnt", chg_cnt, 1);
`endif

    // Reset two cycles into a qualification.
    dif.s1_raw = 4'h5;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst0", {24'h0, dif.s2, dif.s1}, 32'h00);
    tick();
    chk("midrst1", {24'h0, dif.s2, dif.s1}, 32'h00);
    reset = 1'b0;
    hold_check("midrst_hold", 5, 8'h00);
    tick();
    chk("midrst_rise", {24'h0, dif.s2, dif.s1}, 32'hC5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dip_debouncer.md
DIP_DEBOUNCER -- requirements
Module: dip_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 60000, giving the number of consecutive clk cycles a synchronized bit must differ before it is accepted (10 ms at 6 MHz); legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of each per-bit counter; the value must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock (6 MHz HSOSC domain); all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s1_raw, input, 4 bits: asynchronous on-board DIP switches.
REQ-006 SHALL have port s2_raw, input, 4 bits: asynchronous externally wired DIP switches.
REQ-007 SHALL have port s1, output, 4 bits: debounced s1_raw, which feeds the display multiplexer and sum logic.
REQ-008 SHALL have port s2, output, 4 bits: debounced s2_raw.
REQ-009 SHALL have port changed, output, 1 bit: one-cycle update strobe; this port exists only under DIP_DEBOUNCE_CHANGE_EN.

Function
REQ-010 SHALL treat the 8 bits {s2_raw,s1_raw} as independent channels, each with its own synchronizer, counter and stable register.
REQ-011 SHALL pass each raw bit through a 2-flop synchronizer (sync1 then sync2); no other logic shall see a raw bit.
REQ-012 SHALL run the following on each edge, per bit:
- sync2 == stable: cnt <= 0.
- sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
- otherwise: cnt <= cnt+1.
REQ-013 SHALL drive outputs directly from the stable registers, with no combinational path from any input to any output.
REQ-014 SHALL give a fixed latency: if a raw bit changes and holds, it is first sampled at edge k, and the output updates at edge k+DEBOUNCE_CYCLES+1.
REQ-015 SHALL restart qualification on any glitch: a sync2 excursion shorter than DEBOUNCE_CYCLES cycles returns cnt to 0 and leaves the output unchanged.
REQ-016 SHALL never let a counter wrap: cnt never exceeds DEBOUNCE_CYCLES-1.
REQ-017 SHALL, for DEBOUNCE_CYCLES=1, update the output on the first edge at which sync2 differs from stable.
REQ-018 SHALL keep channels independent when they change simultaneously; each channel accepts on its own schedule.

Reset
REQ-019 SHALL, while reset is high at a clk edge, clear all sync1, sync2, stable and cnt registers to 0; s1, s2 and changed then read 0 in the following cycle.
REQ-020 SHALL abandon any in-progress qualification when reset asserts mid-operation; no output changes during reset.
REQ-021 SHALL treat a switch held high through reset release as a normal 0->1 change: sync1 first samples it at the first non-reset edge (edge k), and the output rises at edge k+DEBOUNCE_CYCLES+1.

Configuration
REQ-022 SHALL, with macro DIP_DEBOUNCE_CHANGE_EN defined, include port changed, which is high for exactly the one cycle after any edge where at least one stable bit updated. Multiple bits updating on the same edge produce a single pulse.
REQ-023 SHALL, with DIP_DEBOUNCE_CHANGE_EN undefined, omit port changed and its register; s1/s2 behaviour is identical in both builds.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-024 SHALL cover reset: reset high 2 cycles with s1_raw=4'hF -> s1=0 during reset; after release, s1=4'hF at edge 5 counted from the first non-reset edge.
REQ-025 SHALL cover clean change: s1_raw 0->4'hA, first sampled at edge k and held -> s1=4'hA at edge k+5 and not earlier; changed pulses once (macro on).
REQ-026 SHALL cover a glitch: s2_raw[0] high for 3 cycles, then low -> s2 stays 0 and changed never asserts.
REQ-027 SHALL cover bounce: s2_raw[3] toggles every 2 cycles for 20 cycles, then holds 1 -> s2[3] rises 5 edges after the final hold is first sampled.
REQ-028 SHALL cover simultaneous change: s1_raw=4'h3 and s2_raw=4'hC change on the same edge -> both outputs update on the same edge with a single changed pulse.
REQ-029 SHALL cover reset mid-operation: reset pulsed 2 cycles after s1_raw changes -> s1 stays 0, then updates 5 edges after the first non-reset edge.
